// File: rtl/operand_fetch_pkg.sv
// -----------------------------------------------------------------------------
// operand_fetch_pkg
// Shared definitions for the operand fetch sequencer: FSM state encoding and
// the hard-wired zero register index.
// -----------------------------------------------------------------------------
package operand_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ_A = 2'd1,
        READ_B = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Register index that always reads as zero.
    localparam logic [4:0] ZERO_REG = 5'd0;

endpackage : operand_fetch_pkg

// File: rtl/operand_fetch_if.sv
// -----------------------------------------------------------------------------
// operand_fetch_if
// Bundles the request, register-file read port, snooped write port and operand
// outputs of operand_fetch.
//   master : requester / register file side (drives start, addresses, rd_data,
//            snooped write port; observes rd_addr, operands, busy, done)
//   slave  : operand_fetch side
// -----------------------------------------------------------------------------
interface operand_fetch_if #(
    parameter int width     = 32,
    parameter int addr_bits = 5
);
    logic                 start;
    logic [addr_bits-1:0] rs_addr;
    logic [addr_bits-1:0] rt_addr;
    logic [addr_bits-1:0] rd_addr;
    logic [width-1:0]     rd_data;
    logic                 wr_en;
    logic [addr_bits-1:0] wr_addr;
    logic [width-1:0]     wr_data;
    logic [width-1:0]     a_out;
    logic [width-1:0]     b_out;
    logic                 busy;
    logic                 done;

    modport master (
        output start, rs_addr, rt_addr, rd_data, wr_en, wr_addr, wr_data,
        input  rd_addr, a_out, b_out, busy, done
    );

    modport slave (
        input  start, rs_addr, rt_addr, rd_data, wr_en, wr_addr, wr_data,
        output rd_addr, a_out, b_out, busy, done
    );
endinterface : operand_fetch_if

// File: rtl/operand_fetch_operand_reg.sv
// -----------------------------------------------------------------------------
// operand_reg
// Width-parameterized capture register with load enable.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-high reset, clears o_q to 0
//   i_en  : load enable
//   i_d   : data to capture
//   o_q   : held value
// -----------------------------------------------------------------------------
module operand_reg #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [width-1:0] i_d,
    output logic [width-1:0] o_q
);

    logic [width-1:0] r_q;

    // Capture on enable, otherwise hold the snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= {width{1'b0}};
        end else if (i_en) begin
            r_q <= i_d;
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule : operand_reg

// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch
// Two-cycle read sequencer for the shared register-file read port: fetches
// operand A (rs) then operand B (rt), with same-cycle write forwarding and a
// hard-wired zero register.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-high reset, returns to IDLE
//   bus   : operand_fetch_if.slave (start, rs/rt addresses, read port,
//           snooped write port, a_out/b_out, busy, done)
// -----------------------------------------------------------------------------
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int width     = 32,
    parameter int addr_bits = 5
) (
    input  logic                clk,
    input  logic                reset,
    operand_fetch_if.slave      bus
);

    localparam logic [1:0] ST_IDLE   = 2'(IDLE);
    localparam logic [1:0] ST_READ_A = 2'(READ_A);
    localparam logic [1:0] ST_READ_B = 2'(READ_B);
    localparam logic [1:0] ST_DONE   = 2'(DONE);

    localparam logic [addr_bits-1:0] ZERO_ADDR = addr_bits'(ZERO_REG);

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic                 w_accept;
    logic [addr_bits-1:0] r_rs;
    logic [addr_bits-1:0] r_rt;
    logic                 r_busy;
    logic                 r_done;
    logic [addr_bits-1:0] w_rd_addr;
    logic [width-1:0]     w_operand;
    logic [width-1:0]     w_a_q;
    logic [width-1:0]     w_b_q;

    // Next-state logic; start is only looked at in IDLE and DONE.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next_state = ST_READ_A;
                    w_accept     = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_READ_A: w_next_state = ST_READ_B;
            ST_READ_B: w_next_state = ST_DONE;
            ST_DONE: begin
                if (bus.start) begin
                    w_next_state = ST_READ_A;
                    w_accept     = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State, latched addresses and status flags; busy/done follow next state
    // so they are registered yet aligned with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_rs    <= {addr_bits{1'b0}};
            r_rt    <= {addr_bits{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_rs <= bus.rs_addr;
                r_rt <= bus.rt_addr;
            end
            r_busy <= (w_next_state == ST_READ_A) || (w_next_state == ST_READ_B);
            r_done <= (w_next_state == ST_DONE);
        end
    end

    // Read address is a decode of registered state only.
    always_comb begin
        case (r_state)
            ST_READ_A: w_rd_addr = r_rs;
            ST_READ_B: w_rd_addr = r_rt;
            default:   w_rd_addr = {addr_bits{1'b0}};
        endcase
    end

    // Operand select: zero register wins over forwarding, forwarding over
    // the (stale) register-file read.
    always_comb begin
        if (w_rd_addr == ZERO_ADDR) begin
            w_operand = {width{1'b0}};
        end else if (bus.wr_en && (bus.wr_addr == w_rd_addr)) begin
            w_operand = bus.wr_data;
        end else begin
            w_operand = bus.rd_data;
        end
    end

    operand_reg #(.width(width)) u_reg_a (
        .clk   (clk),
        .reset (reset),
        .i_en  (r_state == ST_READ_A),
        .i_d   (w_operand),
        .o_q   (w_a_q)
    );

    operand_reg #(.width(width)) u_reg_b (
        .clk   (clk),
        .reset (reset),
        .i_en  (r_state == ST_READ_B),
        .i_d   (w_operand),
        .o_q   (w_b_q)
    );

    assign bus.rd_addr = w_rd_addr;
    assign bus.a_out   = w_a_q;
    assign bus.b_out   = w_b_q;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

endmodule : operand_fetch

// File: tb/tb_operand_fetch.sv
// -----------------------------------------------------------------------------
// tb_operand_fetch
// Directed bench for operand_fetch with a small register-file model on the
// read port and hand-computed expected operands.
// -----------------------------------------------------------------------------
module tb_operand_fetch;

    logic clk;
    logic reset;

    operand_fetch_if #(.width(32), .addr_bits(5)) bus ();

    logic [31:0] rf [0:31];
    logic        rf_force;
    logic [31:0] rf_force_val;

    int n_checks;
    int n_errors;

    // Register-file model: combinational read, optionally overridden.
    assign bus.rd_data = rf_force ? rf_force_val : rf[bus.rd_addr];

    operand_fetch #(.width(32), .addr_bits(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs, input logic [4:0] rt);
        bus.start   = 1'b1;
        bus.rs_addr = rs;
        bus.rt_addr = rt;
        tick();
        bus.start   = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[3]        = 32'h3333_3333;
        rf[4]        = 32'h4444_4444;
        rf[5]        = 32'h1111_1111;
        rf[6]        = 32'h6666_6666;
        rf[7]        = 32'hAAAA_AAAA;
        rf[8]        = 32'h8888_8888;
        rf[9]        = 32'h2222_2222;
        rf_force     = 1'b0;
        rf_force_val = 32'h0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.rs_addr  = 5'd0;
        bus.rt_addr  = 5'd0;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = 5'd0;
        bus.wr_data  = 32'h0;

        // Reset state
        tick();
        check_eq("rst_a",    bus.a_out, 32'h0);
        check_eq("rst_b",    bus.b_out, 32'h0);
        check_eq("rst_rd",   {27'd0, bus.rd_addr}, 32'd0);
        check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("rst_done", {31'd0, bus.done}, 32'd0);
        reset = 1'b0;
        tick();
        check_eq("idle_rd", {27'd0, bus.rd_addr}, 32'd0);

        // Basic fetch rs=5 rt=9
        issue(5'd5, 5'd9);
        check_eq("basic_rd_a", {27'd0, bus.rd_addr}, 32'd5);
        check_eq("basic_busy", {31'd0, bus.busy}, 32'd1);
        check_eq("basic_done0", {31'd0, bus.done}, 32'd0);
        tick();
        check_eq("basic_rd_b", {27'd0, bus.rd_addr}, 32'd9);
        check_eq("basic_a", bus.a_out, 32'h1111_1111);
        tick();
        check_eq("basic_done", {31'd0, bus.done}, 32'd1);
        check_eq("basic_busy_off", {31'd0, bus.busy}, 32'd0);
        check_eq("basic_b", bus.b_out, 32'h2222_2222);
        tick();
        check_eq("basic_done_pulse", {31'd0, bus.done}, 32'd0);
        check_eq("basic_idle_rd", {27'd0, bus.rd_addr}, 32'd0);

        // Zero register: forced read data and a write to r0 must not leak
        issue(5'd0, 5'd9);
        rf_force     = 1'b1;
        rf_force_val = 32'hDEAD_BEEF;
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 5'd0;
        bus.wr_data  = 32'h1234_5678;
        tick();
        rf_force     = 1'b0;
        bus.wr_en    = 1'b0;
        check_eq("zero_a", bus.a_out, 32'h0);
        tick();
        check_eq("zero_b", bus.b_out, 32'h2222_2222);
        tick();

        // Bypass on operand B, then the same write after capture
        issue(5'd5, 5'd7);
        tick();
        check_eq("byp_a", bus.a_out, 32'h1111_1111);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd7;
        bus.wr_data = 32'h5555_5555;
        tick();
        check_eq("byp_b", bus.b_out, 32'h5555_5555);
        tick();
        bus.wr_en   = 1'b0;
        check_eq("byp_b_hold", bus.b_out, 32'h5555_5555);
        check_eq("byp_a_hold", bus.a_out, 32'h1111_1111);

        // Back-to-back: start held high, (3,4) then (6,8)
        bus.start   = 1'b1;
        bus.rs_addr = 5'd3;
        bus.rt_addr = 5'd4;
        tick();
        bus.rs_addr = 5'd6;
        bus.rt_addr = 5'd8;
        check_eq("b2b_rd0", {27'd0, bus.rd_addr}, 32'd3);
        tick();
        check_eq("b2b_rd1", {27'd0, bus.rd_addr}, 32'd4);
        check_eq("b2b_a0", bus.a_out, 32'h3333_3333);
        tick();
        check_eq("b2b_done0", {31'd0, bus.done}, 32'd1);
        check_eq("b2b_b0", bus.b_out, 32'h4444_4444);
        tick();
        check_eq("b2b_rd2", {27'd0, bus.rd_addr}, 32'd6);
        check_eq("b2b_gap", {31'd0, bus.done}, 32'd0);
        tick();
        check_eq("b2b_rd3", {27'd0, bus.rd_addr}, 32'd8);
        check_eq("b2b_a1", bus.a_out, 32'h6666_6666);
        tick();
        bus.start = 1'b0;
        check_eq("b2b_done1", {31'd0, bus.done}, 32'd1);
        check_eq("b2b_b1", bus.b_out, 32'h8888_8888);
        tick();
        check_eq("b2b_end_done", {31'd0, bus.done}, 32'd0);
        check_eq("b2b_end_busy", {31'd0, bus.busy}, 32'd0);

        // Ignored start during READ_A
        issue(5'd5, 5'd9);
        bus.start   = 1'b1;
        bus.rs_addr = 5'd3;
        bus.rt_addr = 5'd4;
        tick();
        bus.start   = 1'b0;
        check_eq("ign_rd_b", {27'd0, bus.rd_addr}, 32'd9);
        check_eq("ign_a", bus.a_out, 32'h1111_1111);
        tick();
        check_eq("ign_b", bus.b_out, 32'h2222_2222);
        check_eq("ign_done", {31'd0, bus.done}, 32'd1);
        tick();
        check_eq("ign_no_done", {31'd0, bus.done}, 32'd0);
        check_eq("ign_no_busy", {31'd0, bus.busy}, 32'd0);
        tick();
        check_eq("ign_idle_rd", {27'd0, bus.rd_addr}, 32'd0);
        check_eq("ign_still_no_done", {31'd0, bus.done}, 32'd0);

        // Reset asserted asynchronously in READ_B
        issue(5'd3, 5'd4);
        tick();
        check_eq("mid_in_readb", {27'd0, bus.rd_addr}, 32'd4);
        #2;
        reset = 1'b1;
        #1;
        check_eq("mid_a", bus.a_out, 32'h0);
        check_eq("mid_b", bus.b_out, 32'h0);
        check_eq("mid_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("mid_done", {31'd0, bus.done}, 32'd0);
        check_eq("mid_rd", {27'd0, bus.rd_addr}, 32'd0);
        reset = 1'b0;
        tick();
        check_eq("post_rst_done", {31'd0, bus.done}, 32'd0);
        check_eq("post_rst_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("post_rst_b", bus.b_out, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_operand_fetch

// File: doc/operand_fetch.md
# operand_fetch

Read-side sequencer for the multicycle CPU register file. It drives the single shared read port of the register file over two cycles, fetching operand A (rs) and then operand B (rt). Each operand is captured into a holding register and presented to the ALU datapath. It also snoops the register-file write port, so a same-cycle write to the address being read is forwarded instead of returning the stale value.

## Interface
Parameters:
- width, 32, data width of register contents and operands
- addr_bits, 5, register address width

Ports:
- clk  in  1  single system clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; returns block to IDLE immediately
- start  in  1  request to fetch operands; sampled only in IDLE or DONE
- rs_addr  in  addr_bits  operand A register index, latched on accepted start
- rt_addr  in  addr_bits  operand B register index, latched on accepted start
- rd_addr  out  addr_bits  address driven to register-file read port
- rd_data  in  width  combinational read data returned for rd_addr
- wr_en  in  1  register-file write enable (snooped)
- wr_addr  in  addr_bits  register-file write address (snooped)
- wr_data  in  width  register-file write data (snooped)
- a_out  out  width  captured operand A
- b_out  out  width  captured operand B
- busy  out  1  high in READ_A and READ_B
- done  out  1  one-cycle pulse: both operands valid

## Operation
- States: IDLE, READ_A, READ_B, DONE.
- IDLE: rd_addr=0. start=1 latches rs_addr/rt_addr and moves to READ_A. start=0 stays in IDLE.
- READ_A: rd_addr=latched rs. At the clock edge, a_out captures the operand value, then the state moves to READ_B.
- READ_B: rd_addr=latched rt. At the clock edge, b_out captures the operand value, then the state moves to DONE.
- DONE: done=1. start=1 latches new addresses and goes to READ_A (back-to-back); otherwise goes to IDLE.
- Operand value, in priority order:
  - address 0 gives 0, regardless of rd_data or bypass;
  - else, if wr_en=1 and wr_addr equals the read address, gives wr_data;
  - else gives rd_data.
- Captured operands are not updated by writes after their capture cycle (snapshot semantics).
- start in READ_A or READ_B is ignored; no queuing.
- a_out/b_out hold their values until the next capture, including through IDLE.

## Timing
- Reset values: state=IDLE, a_out=0, b_out=0, rd_addr=0, busy=0, done=0, latched addresses=0.
- Reset mid-operation aborts immediately. done is not pulsed for the aborted fetch, and outputs return to their reset values.
- Latency: start accepted at edge N. a_out is valid after edge N+1, b_out after edge N+2, and done is high during the cycle after edge N+2.
- Back-to-back fetch: start held high delivers one done every 3 cycles.
- rd_addr is registered state decode only; no combinational path from start to rd_addr.
- Bypass is combinational from wr_* to the capture register input; there is no path to any output in the same cycle.
- rs==rt is legal; both operands receive the same value, subject to each cycle's own bypass condition.

## Structure
- Shared package:
  - state enum (IDLE=2'd0, READ_A=2'd1, READ_B=2'd2, DONE=2'd3);
  - ZERO_REG constant (5'd0).
- One sub-module, operand_reg: width-parameterized capture register with write enable and async active-high reset to 0. It is instantiated twice (A and B).
- Operand select (zero/bypass/read) is a small always_comb block in the top; no separate module.

## Test plan
- Basic fetch: reg5=0x1111_1111, reg9=0x2222_2222; start with rs=5, rt=9 -> rd_addr 5 then 9; done at cycle 3; a_out=0x1111_1111, b_out=0x2222_2222.
- Zero register: rs=0, with rd_data forced to 0xDEAD_BEEF and wr_en=1, wr_addr=0 in READ_A -> a_out=0.
- Bypass: reg7 holds 0xAAAA_AAAA; rt=7; wr_en=1, wr_addr=7, wr_data=0x5555_5555 during READ_B -> b_out=0x5555_5555. The same write one cycle later -> b_out remains 0x5555_5555 and is not recaptured.
- Back-to-back: start held high for two fetches (3,4) then (6,8) -> done pulses in cycles 3 and 6; rd_addr sequence 3,4,6,8.
- Ignored start: start pulsed during READ_A with different addresses -> original addresses used; exactly one done.
- Reset mid-op: assert reset asynchronously in READ_B -> a_out=0, b_out=0, busy=0, no done pulse, rd_addr=0 before the next clk edge.
